// File: rtl/alu_exec_stage.sv
// Integer execute stage: EX operand slot, combinational ALU, WB result slot
// broadcast to the CDB under valid/ready, with branch kill/fix on spec tags.
module alu_exec_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 6,
  parameter int SPEC_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_src1,
  input  logic [DATA_W-1:0] issue_src2,
  input  logic [TAG_W-1:0]  issue_rrftag,
  input  logic [SPEC_W-1:0] issue_spectag,
  input  logic              kill_valid,
  input  logic [SPEC_W-1:0] kill_mask,
  input  logic              fix_valid,
  input  logic [SPEC_W-1:0] fix_mask,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_rrftag,
  output logic              busy
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] ALU_OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_OP_SLL  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_OP_SLT  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OP_SLTU = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_OP_SRL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_OP_AND  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_OP_SUB  = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_OP_SRA  = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_OP_SEQ  = OP_W'(10);
  localparam logic [OP_W-1:0] ALU_OP_SNE  = OP_W'(11);
  localparam logic [OP_W-1:0] ALU_OP_SGE  = OP_W'(12);
  localparam logic [OP_W-1:0] ALU_OP_SGEU = OP_W'(13);

  logic              ex_valid_reg, ex_valid_next;
  logic [OP_W-1:0]   ex_op_reg, ex_op_next;
  logic [DATA_W-1:0] ex_src1_reg, ex_src1_next;
  logic [DATA_W-1:0] ex_src2_reg, ex_src2_next;
  logic [TAG_W-1:0]  ex_tag_reg, ex_tag_next;
  logic [SPEC_W-1:0] ex_spec_reg, ex_spec_next;

  logic              wb_valid_reg, wb_valid_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic [TAG_W-1:0]  wb_tag_reg, wb_tag_next;
  logic [SPEC_W-1:0] wb_spec_reg, wb_spec_next;

  logic              ex_advance;
  logic              issue_fire;
  logic [SPEC_W-1:0] kill_vec;
  logic [SPEC_W-1:0] fix_vec;
  logic              ex_kill;
  logic              wb_kill;
  logic              in_kill;

  logic [DATA_W-1:0] and_vec;
  logic [DATA_W-1:0] or_vec;
  logic [DATA_W-1:0] xor_vec;
  logic [SH_W-1:0]   shamt;
  logic              lt_s;
  logic              lt_u;
  logic              eq;
  logic [DATA_W-1:0] alu_result;

  // ---------------- combinational ALU on EX slot registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bitwise
      assign and_vec[gi] = ex_src1_reg[gi] & ex_src2_reg[gi];
      assign or_vec[gi]  = ex_src1_reg[gi] | ex_src2_reg[gi];
      assign xor_vec[gi] = ex_src1_reg[gi] ^ ex_src2_reg[gi];
    end
  endgenerate

  assign shamt = ex_src2_reg[SH_W-1:0];
  assign lt_s  = $signed(ex_src1_reg) < $signed(ex_src2_reg);
  assign lt_u  = ex_src1_reg < ex_src2_reg;
  assign eq    = ex_src1_reg == ex_src2_reg;

  always_comb begin
    alu_result = '0;
    case (ex_op_reg)
      ALU_OP_ADD:  alu_result = ex_src1_reg + ex_src2_reg;
      ALU_OP_SUB:  alu_result = ex_src1_reg - ex_src2_reg;
      ALU_OP_SLL:  alu_result = ex_src1_reg << shamt;
      ALU_OP_SRL:  alu_result = ex_src1_reg >> shamt;
      ALU_OP_SRA:  alu_result = DATA_W'($signed(ex_src1_reg) >>> shamt);
      ALU_OP_AND:  alu_result = and_vec;
      ALU_OP_OR:   alu_result = or_vec;
      ALU_OP_XOR:  alu_result = xor_vec;
      ALU_OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, lt_u};
      ALU_OP_SGE:  alu_result = {{(DATA_W-1){1'b0}}, ~lt_s};
      ALU_OP_SGEU: alu_result = {{(DATA_W-1){1'b0}}, ~lt_u};
      ALU_OP_SEQ:  alu_result = {{(DATA_W-1){1'b0}}, eq};
      ALU_OP_SNE:  alu_result = {{(DATA_W-1){1'b0}}, ~eq};
      default:     alu_result = '0;
    endcase
  end

  // ---------------- handshake and branch resolution ----------------
  // Advance and ready deliberately ignore kill so issue_ready never sees it.
  assign ex_advance  = ex_valid_reg & (~wb_valid_reg | cdb_ready);
  assign issue_ready = ~ex_valid_reg | ex_advance;
  assign issue_fire  = issue_valid & issue_ready;

  assign kill_vec = kill_valid ? kill_mask : '0;
  assign fix_vec  = fix_valid  ? fix_mask  : '0;
  assign ex_kill  = |(ex_spec_reg   & kill_vec);
  assign wb_kill  = |(wb_spec_reg   & kill_vec);
  assign in_kill  = |(issue_spectag & kill_vec);

  always_comb begin
    ex_valid_next = ex_valid_reg;
    ex_op_next    = ex_op_reg;
    ex_src1_next  = ex_src1_reg;
    ex_src2_next  = ex_src2_reg;
    ex_tag_next   = ex_tag_reg;
    ex_spec_next  = ex_spec_reg & ~fix_vec;
    wb_valid_next = wb_valid_reg;
    wb_data_next  = wb_data_reg;
    wb_tag_next   = wb_tag_reg;
    wb_spec_next  = wb_spec_reg & ~fix_vec;

    // WB: refill from EX, drain to CDB, or drop on kill while stalled
    if (ex_advance) begin
      wb_valid_next = ~ex_kill;
      if (!ex_kill) begin
        wb_data_next = alu_result;
        wb_tag_next  = ex_tag_reg;
        wb_spec_next = ex_spec_reg & ~fix_vec;
      end
    end else if (cdb_ready | wb_kill) begin
      wb_valid_next = 1'b0;
    end

    // EX: a killed incoming op leaves the slot untouched but empty
    if (issue_fire) begin
      ex_valid_next = ~in_kill;
      if (!in_kill) begin
        ex_op_next   = issue_op;
        ex_src1_next = issue_src1;
        ex_src2_next = issue_src2;
        ex_tag_next  = issue_rrftag;
        ex_spec_next = issue_spectag & ~fix_vec;
      end
    end else if (ex_advance | ex_kill) begin
      ex_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_reg <= 1'b0;
      ex_op_reg    <= '0;
      ex_src1_reg  <= '0;
      ex_src2_reg  <= '0;
      ex_tag_reg   <= '0;
      ex_spec_reg  <= '0;
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
      wb_tag_reg   <= '0;
      wb_spec_reg  <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      ex_op_reg    <= ex_op_next;
      ex_src1_reg  <= ex_src1_next;
      ex_src2_reg  <= ex_src2_next;
      ex_tag_reg   <= ex_tag_next;
      ex_spec_reg  <= ex_spec_next;
      wb_valid_reg <= wb_valid_next;
      wb_data_reg  <= wb_data_next;
      wb_tag_reg   <= wb_tag_next;
      wb_spec_reg  <= wb_spec_next;
    end
  end

  assign cdb_valid  = wb_valid_reg;
  assign cdb_data   = wb_data_reg;
  assign cdb_rrftag = wb_tag_reg;
  assign busy       = ex_valid_reg | wb_valid_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios plus randomized traffic, checked
// every cycle against an in-order queue model of in-flight ops.
module tb_alu_exec_stage;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 6;
  localparam int SPEC_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SLL = 4'd1, OP_SLT = 4'd2, OP_SLTU = 4'd3,
                         OP_XOR = 4'd4, OP_SRL = 4'd5, OP_OR = 4'd6, OP_AND = 4'd7,
                         OP_SUB = 4'd8, OP_SRA = 4'd9, OP_SEQ = 4'd10, OP_SNE = 4'd11,
                         OP_SGE = 4'd12, OP_SGEU = 4'd13;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_src1;
  logic [DATA_W-1:0] issue_src2;
  logic [TAG_W-1:0]  issue_rrftag;
  logic [SPEC_W-1:0] issue_spectag;
  logic              kill_valid;
  logic [SPEC_W-1:0] kill_mask;
  logic              fix_valid;
  logic [SPEC_W-1:0] fix_mask;
  logic              cdb_valid;
  logic              cdb_ready;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_rrftag;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .SPEC_W(SPEC_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_rrftag(issue_rrftag),
    .issue_spectag(issue_spectag), .kill_valid(kill_valid), .kill_mask(kill_mask),
    .fix_valid(fix_valid), .fix_mask(fix_mask), .cdb_valid(cdb_valid),
    .cdb_ready(cdb_ready), .cdb_data(cdb_data), .cdb_rrftag(cdb_rrftag), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SGE:  return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
      OP_SGEU: return (a >= b) ? 32'd1 : 32'd0;
      OP_SEQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_SNE:  return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // In-flight ops, oldest first; at most one is in WB (the oldest) and one waits in EX.
  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    logic [4:0]  spec;
    bit          in_wb;
  } ent_t;
  ent_t flight[$];
  int   n_xfer = 0;

  task automatic idle_inputs();
    issue_valid = 0; issue_op = '0; issue_src1 = '0; issue_src2 = '0;
    issue_rrftag = '0; issue_spectag = '0;
    kill_valid = 0; kill_mask = '0; fix_valid = 0; fix_mask = '0;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] tag, input logic [4:0] spec);
    issue_valid = 1; issue_op = op; issue_src1 = a; issue_src2 = b;
    issue_rrftag = tag; issue_spectag = spec;
  endtask

  // Called at a falling edge with inputs applied: compare, advance model, cross one edge.
  task automatic tick();
    bit wb_p, ex_p, adv, rdy, killed;
    logic [4:0] kv, fv;
    ent_t e;
    ent_t nf[$];
    #1;
    wb_p = flight.size() > 0 && flight[0].in_wb;
    ex_p = flight.size() > 0 && !flight[flight.size()-1].in_wb;
    adv  = ex_p && (!wb_p || cdb_ready);
    rdy  = !ex_p || adv;
    check("issue_ready", issue_ready, rdy);
    check("cdb_valid", cdb_valid, wb_p);
    check("busy", busy, flight.size() > 0);
    if (wb_p) begin
      check("cdb_data", cdb_data, flight[0].data);
      check("cdb_rrftag", cdb_rrftag, flight[0].tag);
    end
    kv = kill_valid ? kill_mask : 5'd0;
    fv = fix_valid ? fix_mask : 5'd0;
    foreach (flight[i]) begin
      e = flight[i];
      killed = (e.spec & kv) != 0;
      if (e.in_wb) begin
        if (cdb_ready && !killed) begin
          n_xfer++;
          $display("CDB xfer tag=%0d data=0x%08h t=%0t", e.tag, e.data, $time);
        end else if (!cdb_ready && !killed) begin
          e.spec = e.spec & ~fv;
          nf.push_back(e);
        end
      end else if (!killed) begin
        if (adv) e.in_wb = 1;
        e.spec = e.spec & ~fv;
        nf.push_back(e);
      end
    end
    if (issue_valid && rdy && (issue_spectag & kv) == 0) begin
      e.tag = issue_rrftag; e.spec = issue_spectag & ~fv; e.in_wb = 0;
      e.data = ref_alu(issue_op, issue_src1, issue_src2);
      nf.push_back(e);
    end
    flight = nf;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; cdb_ready = 0;
    idle_inputs();
    @(negedge clk);
    #1;
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_rrftag", cdb_rrftag, 0);
    check("rst_issue_ready", issue_ready, 1);
    @(negedge clk);

    // Basic latency: result appears two edges after issue, for one cycle.
    cdb_ready = 1;
    set_issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 6'd5, 5'd0);
    tick();
    idle_inputs();
    check("lat_not_yet", cdb_valid, 0);
    tick();
    check("lat_valid", cdb_valid, 1);
    check("lat_data", cdb_data, 32'h8000_0000);
    check("lat_tag", cdb_rrftag, 5);
    tick();
    check("lat_one_wide", cdb_valid, 0);
    tick();

    // Back-to-back throughput.
    set_issue(OP_SUB, 32'd3, 32'd5, 6'd1, 5'd0);           tick();
    set_issue(OP_XOR, 32'hF0F0, 32'hFF, 6'd2, 5'd0);        tick();
    check("tp_r1", cdb_data, 32'hFFFF_FFFE);
    set_issue(OP_SLTU, 32'd1, 32'd2, 6'd3, 5'd0);           tick();
    check("tp_r2", cdb_data, 32'h0000_F00F);
    set_issue(OP_SLT, 32'hFFFF_FFFF, 32'd0, 6'd4, 5'd0);    tick();
    check("tp_r3", cdb_data, 1);
    idle_inputs();                                          tick();
    check("tp_r4", cdb_data, 1);
    tick(); tick();

    // Backpressure: third op refused until WB drains.
    cdb_ready = 0;
    set_issue(OP_ADD, 32'd10, 32'd20, 6'd20, 5'd0); tick();
    set_issue(OP_ADD, 32'd11, 32'd21, 6'd21, 5'd0); tick();
    set_issue(OP_ADD, 32'd12, 32'd22, 6'd22, 5'd0); tick();
    check("bp_full_ready", issue_ready, 0);
    check("bp_stable_data", cdb_data, 30);
    tick();
    cdb_ready = 1; tick();
    idle_inputs(); tick(); tick(); tick(); tick();

    // Kill: stalled WB and incoming op squashed; EX survives and broadcasts.
    cdb_ready = 0;
    set_issue(OP_OR, 32'h1, 32'h2, 6'd10, 5'b00010); tick();
    set_issue(OP_OR, 32'h4, 32'h8, 6'd11, 5'b00100); tick();
    set_issue(OP_OR, 32'h10, 32'h20, 6'd12, 5'b00010);
    kill_valid = 1; kill_mask = 5'b00010; cdb_ready = 1;
    tick();
    idle_inputs();
    check("kill_surv_tag", cdb_rrftag, 11);
    check("kill_surv_data", cdb_data, 32'hC);
    tick(); tick(); tick();

    // Fix+kill same cycle, kill uses the pre-fix tag.
    set_issue(OP_ADD, 32'd1, 32'd1, 6'd30, 5'b00011); tick();
    idle_inputs();
    kill_valid = 1; kill_mask = 5'b00010; fix_valid = 1; fix_mask = 5'b00001;
    tick();
    idle_inputs();
    check("fk_killed", cdb_valid, 0);
    tick();
    cdb_ready = 0;
    set_issue(OP_ADD, 32'd2, 32'd2, 6'd31, 5'b00011); tick();
    idle_inputs();
    kill_valid = 1; kill_mask = 5'b01000; fix_valid = 1; fix_mask = 5'b00001;
    tick();
    idle_inputs();
    check("fk_survive", cdb_valid, 1);
    tick();
    kill_valid = 1; kill_mask = 5'b00010;
    tick();
    idle_inputs();
    check("fk_later_kill", cdb_valid, 0);
    tick();

    // Async reset mid-flight.
    cdb_ready = 0;
    set_issue(OP_ADD, 32'd5, 32'd6, 6'd40, 5'd0); tick();
    set_issue(OP_ADD, 32'd7, 32'd8, 6'd41, 5'd0); tick();
    idle_inputs();
    #2 reset_n = 0;
    #1;
    check("arst_cdb_valid", cdb_valid, 0);
    check("arst_busy", busy, 0);
    flight.delete();
    @(negedge clk);
    reset_n = 1;
    cdb_ready = 1;
    for (int k = 0; k < 4; k++) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] km;
      idle_inputs();
      if ($urandom_range(0, 3) != 0) begin
        set_issue(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom,
                  6'($urandom), ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0);
      end
      cdb_ready = ($urandom_range(0, 3) != 0);
      km = 5'd1 << $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) begin
        kill_valid = 1; kill_mask = km;
      end
      if ($urandom_range(0, 5) == 0) begin
        fix_valid = 1; fix_mask = 5'($urandom) & ~km;
      end
      tick();
    end
    idle_inputs();
    cdb_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    check("drain_empty", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Integer execute pipeline stage wrapped around the existing combinational integer ALU.
- Accepts issued ALU micro-ops from the ALU reservation station and registers operands (EX slot).
- Evaluates the ALU and registers the result with its rename tag (WB slot).
- Broadcasts the result to the CDB arbiter under a valid/ready handshake.
- Squashes wrong-path ops on branch mispredict and clears speculative tag bits on branch success.

Parameters:
- DATA_W, 32, operand/result width (XPR_LEN).
- OP_W, 4, ALU op code width (ALU_OP_WIDTH).
- TAG_W, 6, rename-register (RRF) tag width.
- SPEC_W, 5, speculative branch tag mask width (one-hot per in-flight branch).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issue request from reservation station.
- issue_ready  out  1  stage can accept an op this cycle.
- issue_op  in  OP_W  ALU op code.
- issue_src1  in  DATA_W  operand 1.
- issue_src2  in  DATA_W  operand 2, already immediate-selected.
- issue_rrftag  in  TAG_W  destination rename tag.
- issue_spectag  in  SPEC_W  branches this op depends on; 0 means non-speculative.
- kill_valid  in  1  branch mispredict.
- kill_mask  in  SPEC_W  mispredicted branch bit(s).
- fix_valid  in  1  branch resolved correct.
- fix_mask  in  SPEC_W  resolved branch bit(s).
- cdb_valid  out  1  result available.
- cdb_ready  in  1  CDB arbiter accepts the result.
- cdb_data  out  DATA_W  ALU result.
- cdb_rrftag  out  TAG_W  destination tag of the result.
- busy  out  1  either slot occupied.

Behaviour:
- Reset (async, reset_n=0):
  - ex_valid=0, wb_valid=0; cdb_valid=0, cdb_data=0, cdb_rrftag=0; issue_ready=1 after reset; busy=0.
  - All internal operand, tag and op registers clear to 0.
  - Reset asserted mid-operation discards both slots immediately; no broadcast follows deassertion.
- Handshakes:
  - An issue transfer occurs when issue_valid & issue_ready on a rising edge.
  - A CDB transfer occurs when cdb_valid & cdb_ready.
- Pipeline:
  - Issue writes the EX slot (op, src1, src2, rrftag, spectag).
  - The ALU evaluates combinationally from EX slot registers.
  - EX advances into WB, capturing the ALU output, tag and spectag, when ex_valid & (!wb_valid | cdb_ready).
  - Latency: issue at edge N -> cdb_valid high after edge N+1; earliest CDB transfer at edge N+2.
  - Throughput: 1 op/cycle while cdb_ready is held high.
- Ready and stall:
  - issue_ready = !ex_valid | ex_advance; combinational, independent of issue_valid.
  - WB is held stable (data, tag, valid) while cdb_valid & !cdb_ready.
  - EX is held while WB is blocked.
  - Full condition: both slots valid and cdb_ready=0 -> issue_ready=0.
- Outputs: cdb_valid = wb_valid; cdb_data/cdb_rrftag come straight from WB registers, with no combinational path from issue inputs.
- Kill (kill_valid=1):
  - Any slot or incoming issue with (spectag & kill_mask) != 0 is invalidated at that edge.
  - An incoming op that matches is not written; issue_ready is unaffected by the kill.
  - A killed WB entry never completes a CDB transfer, even if cdb_ready=1 that cycle.
  - cdb_valid falls at the edge and is not masked combinationally.
  - An EX entry killed while advancing does not enter WB.
  - Survivors advance normally in the same cycle.
- Fix (fix_valid=1): every surviving slot and the incoming op get spectag &= ~fix_mask.
- Kill and fix in the same cycle:
  - The kill match uses the pre-fix spectag.
  - The fix is applied to survivors.
  - Masks are disjoint by construction; overlap is not checked.
- ALU result width: DATA_W, with wrap-around arithmetic (ADD/SUB modulo 2^DATA_W).
- Compare ops yield 0/1 zero-extended.
- Undefined op codes yield 0 and still broadcast.

Test Plan:
- Basic latency: after reset, issue ALU_OP_ADD src1=0x7FFFFFFF src2=1 tag=5 with cdb_ready=1 -> cdb_valid exactly 2 edges later with data=0x80000000, tag=5, one cycle wide.
- Back-to-back throughput: 4 consecutive issues (SUB 3-5, XOR 0xF0F0^0xFF, SLTU 1<2, SLT 0xFFFFFFFF<0), tags 1..4, cdb_ready=1 -> results 0xFFFFFFFE, 0xF00F, 1, 1 on 4 consecutive cycles; issue_ready never low.
- Backpressure: cdb_ready=0 with 3 issues offered -> 2 accepted, issue_ready=0 on the 3rd, cdb_data stable. Raise cdb_ready -> in-order drain, the 3rd is accepted the same cycle WB drains, no loss or duplicate.
- Kill: WB spectag=00010 (stalled), EX spectag=00100, incoming issue spectag=00010, kill_mask=00010 -> WB and incoming are dropped. EX moves to WB and is broadcast next cycle; no tag from the killed ops ever appears.
- Fix+kill same cycle: EX spectag=00011, fix_mask=00001, kill_mask=00010 -> EX is killed. Repeat with kill_mask=01000 -> EX survives with spectag=00010; a later kill_mask=00010 squashes it.
- Async reset mid-flight: both slots full, assert reset_n low between clock edges -> cdb_valid drops immediately. After release, no broadcast occurs until a new issue.
